// File: rtl/mul_booth4_iter.sv
// Iterative radix-4 Booth multiplier: two partial products per cycle are folded into a
// redundant sum/carry accumulator by a 4:2 compressor, then resolved by one final add.
module mul_booth4_iter #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  mul_valid,
  output logic                  mul_ready,
  input  logic [DATA_WIDTH-1:0] mul_a,
  input  logic [DATA_WIDTH-1:0] mul_b,
  input  logic                  mul_a_signed,
  input  logic                  mul_b_signed,
  input  logic                  mul_high,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned W         = DATA_WIDTH;
  localparam int unsigned XW        = W + 2;
  localparam int unsigned PW        = 2 * W;
  localparam int unsigned NumDigits = W / 2 + 1;
  localparam int unsigned NumIter   = (NumDigits + 1) / 2;
  localparam int unsigned CntW      = $clog2(NumIter + 1);
  // Wide enough that the (zeroed) digit past the end can still be sliced safely.
  localparam int unsigned BPadW     = 4 * NumIter + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StAdd, StDone} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   a_q, b_q;
  logic            high_q;
  logic [PW-1:0]   s_q, c_q, s_d, c_d;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    result_q;
  logic            res_valid_q;

  logic [BPadW-1:0] b_pad;
  logic [PW-1:0]    a_wide, pp0, pp1, s1, c1, prod;
  logic [CntW:0]    idx0, idx1;

  function automatic logic [PW-1:0] booth_pp(input logic [2:0] bits, input logic [PW-1:0] a);
    logic [PW-1:0] pp;
    pp = '0;
    case (bits)
      3'b001, 3'b010: pp = a;
      3'b011:         pp = a << 1;
      3'b100:         pp = -(a << 1);
      3'b101, 3'b110: pp = -a;
      default:        pp = '0;
    endcase
    return pp;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush outranks everything.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (mul_valid) state_d = StCalc;
        StCalc: if (cnt_q == CntW'(NumIter - 1)) state_d = StAdd;
        StAdd:  state_d = StDone;
        StDone: if (res_ready) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    mul_ready = (state_q == StIdle);
    res_valid = res_valid_q;
    result    = result_q;
  end

  // Partial products and 4:2 compression (two chained carry-save levels).
  always_comb begin
    b_pad  = '0;
    b_pad[XW:0] = {b_q, 1'b0};
    a_wide = {{(PW - XW){a_q[XW-1]}}, a_q};
    idx0   = {cnt_q, 1'b0};
    idx1   = idx0 + (CntW + 1)'(1);
    pp0    = '0;
    pp1    = '0;
    if (idx0 < (CntW + 1)'(NumDigits)) begin
      pp0 = booth_pp(b_pad[{idx0, 1'b0} +: 3], a_wide) << {idx0, 1'b0};
    end
    if (idx1 < (CntW + 1)'(NumDigits)) begin
      pp1 = booth_pp(b_pad[{idx1, 1'b0} +: 3], a_wide) << {idx1, 1'b0};
    end
    s1   = pp0 ^ pp1 ^ s_q;
    c1   = ((pp0 & pp1) | (pp0 & s_q) | (pp1 & s_q)) << 1;
    s_d  = s1 ^ c1 ^ c_q;
    c_d  = ((s1 & c1) | (s1 & c_q) | (c1 & c_q)) << 1;
    prod = s_q + c_q;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      high_q      <= 1'b0;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
    end else if (flush) begin
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mul_valid) begin
            a_q    <= {{2{mul_a_signed & mul_a[W-1]}}, mul_a};
            b_q    <= {{2{mul_b_signed & mul_b[W-1]}}, mul_b};
            high_q <= mul_high;
            s_q    <= '0;
            c_q    <= '0;
            cnt_q  <= '0;
          end
        end
        StCalc: begin
          s_q   <= s_d;
          c_q   <= c_d;
          cnt_q <= cnt_q + CntW'(1);
        end
        StAdd: begin
          result_q    <= high_q ? prod[PW-1:W] : prod[W-1:0];
          res_valid_q <= 1'b1;
        end
        StDone: begin
          if (res_ready) res_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_booth4_iter.sv
// Self-checking bench for mul_booth4_iter: directed corner cases plus random operands
// compared against a plain 128-bit arithmetic model.
module tb_mul_booth4_iter;

  localparam int W   = 64;
  localparam int LAT = 18;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         mul_valid = 1'b0;
  logic         mul_ready;
  logic [W-1:0] mul_a = '0;
  logic [W-1:0] mul_b = '0;
  logic         mul_a_signed = 1'b0;
  logic         mul_b_signed = 1'b0;
  logic         mul_high = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  mul_booth4_iter #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .mul_valid    (mul_valid),
    .mul_ready    (mul_ready),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_a_signed (mul_a_signed),
    .mul_b_signed (mul_b_signed),
    .mul_high     (mul_high),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .result       (result)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic as, input logic bs, input logic hi);
    logic [2*W-1:0] ae, be, p;
    ae = as ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    be = bs ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = ae * be;
    return hi ? p[2*W-1:W] : p[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic as, input logic bs, input logic hi);
    int n = 0;
    while (!mul_ready && n < 50) begin
      step();
      n++;
    end
    check("ready_before_accept", W'(mul_ready), W'(1));
    mul_a = a; mul_b = b; mul_a_signed = as; mul_b_signed = bs; mul_high = hi;
    mul_valid = 1'b1;
    step();
    mul_valid = 1'b0;
    mul_a = '1; mul_b = '1; mul_high = ~hi;  // must not be resampled while busy
  endtask

  task automatic finish_op(input string tag, input logic [W-1:0] exp, input int hold);
    int lat = 0;
    logic busy_ok = 1'b1;
    logic [W-1:0] first;
    while (!res_valid && lat < 100) begin
      if (mul_ready) busy_ok = 1'b0;
      step();
      lat++;
    end
    check({tag, "_latency"}, W'(lat), W'(LAT));
    check({tag, "_busy"}, W'(busy_ok), W'(1));
    check(tag, result, exp);
    first = result;
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_valid"}, W'(res_valid), W'(1));
      check({tag, "_hold_result"}, result, first);
      check({tag, "_hold_ready"}, W'(mul_ready), W'(0));
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, W'(res_valid), W'(0));
    check({tag, "_back_idle"}, W'(mul_ready), W'(1));
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic as, input logic bs, input logic hi, input int hold);
    start(a, b, as, bs, hi);
    finish_op(tag, model(a, b, as, bs, hi), hold);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         ras, rbs, rhi;
    step();
    step();
    check("reset_ready", W'(mul_ready), W'(1));
    check("reset_valid", W'(res_valid), W'(0));
    check("reset_result", result, '0);
    rst = 1'b0;

    run("u3x5", 64'd3, 64'd5, 1'b0, 1'b0, 1'b0, 0);
    check("u3x5_const", result, 64'h000000000000000F);
    run("s_m1m1_hi", '1, '1, 1'b1, 1'b1, 1'b1, 0);
    check("s_m1m1_hi_const", result, 64'h0);
    run("s_m1m1_lo", '1, '1, 1'b1, 1'b1, 1'b0, 0);
    check("s_m1m1_lo_const", result, 64'h1);
    run("u_max2_hi", '1, 64'd2, 1'b0, 1'b0, 1'b1, 0);
    check("u_max2_hi_const", result, 64'h1);
    run("u_max2_lo", '1, 64'd2, 1'b0, 1'b0, 1'b0, 0);
    check("u_max2_lo_const", result, 64'hFFFFFFFFFFFFFFFE);
    run("mulhsu", '1, '1, 1'b1, 1'b0, 1'b1, 0);
    check("mulhsu_const", result, 64'hFFFFFFFFFFFFFFFF);
    run("s_minmin_hi", 64'h8000000000000000, 64'h8000000000000000, 1'b1, 1'b1, 1'b1, 0);
    check("s_minmin_hi_const", result, 64'h4000000000000000);

    // Backpressure: result held for 5 cycles, then a new request goes straight through.
    run("backpressure", 64'h123456789ABCDEF0, 64'hFEDCBA9876543210, 1'b1, 1'b0, 1'b1, 5);
    run("after_bp", 64'd11, 64'd13, 1'b0, 1'b0, 1'b0, 0);

    // Flush during CALC cycle 7; a request presented with flush must be dropped.
    start(64'd99, 64'd99, 1'b0, 1'b0, 1'b0);
    repeat (7) step();
    flush = 1'b1;
    step();
    check("flush_idle", W'(mul_ready), W'(1));
    check("flush_valid", W'(res_valid), W'(0));
    mul_valid = 1'b1;
    step();
    mul_valid = 1'b0;
    flush = 1'b0;
    check("flush_no_accept", W'(mul_ready), W'(1));
    check("flush_no_valid", W'(res_valid), W'(0));
    run("post_flush", 64'd7, 64'd6, 1'b0, 1'b0, 1'b0, 0);
    check("post_flush_const", result, 64'd42);

    // Synchronous reset mid-operation.
    start(64'd5, 64'd5, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_valid", W'(res_valid), W'(0));
    check("rst_mid_result", result, '0);
    check("rst_mid_ready", W'(mul_ready), W'(1));
    run("post_rst", 64'd2, 64'd2, 1'b0, 1'b0, 1'b0, 0);
    check("post_rst_const", result, 64'd4);

    for (int i = 0; i < 24; i++) begin
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if (i % 6 == 1) ra = 64'h8000000000000000;
      if (i % 6 == 4) rb = {$urandom_range(1, 0) == 1 ? 1'b1 : 1'b0, 63'd0};
      ras = 1'($urandom_range(1, 0));
      rbs = 1'($urandom_range(1, 0));
      rhi = 1'($urandom_range(1, 0));
      run("random", ra, rb, ras, rbs, rhi, i % 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
